// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the data-cache load/store handshake, aligns load data and holds results for write-back.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned loads/stores skip the cache and raise mem_misalign.
module mem_access_stage #(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_enable,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   store_data,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        dest_reg,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic              dc_req_write,
  output logic [ADDR_W-1:0] dc_req_addr,
  output logic [XLEN-1:0]   dc_req_wdata,
  output logic [7:0]        dc_req_strb,
  input  logic              dc_resp_valid,
  input  logic [XLEN-1:0]   dc_resp_rdata,
  output logic [XLEN-1:0]   loaded_data,
  output logic [XLEN-1:0]   alu_result_out,
  output logic [4:0]        dest_reg_out,
  output logic [6:0]        opcode_out,
  output logic              mem_done,
  input  logic              wb_ack,
  output logic              mem_misalign
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_r, state_next_s;
  logic [2:0]        funct3_r;
  logic [2:0]        off_in_s;
  logic              is_load_s, is_store_s, is_mem_s, trap_s;
  logic [ADDR_W-1:0] addr_full_s;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // Bytes past the doubleword end are already zero after the right shift.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] rdata,
                                                  input logic [2:0] off,
                                                  input logic [2:0] f3);
    logic [XLEN-1:0] raw;
    raw = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  extend_load = {{(XLEN-8){raw[7]}}, raw[7:0]};
      3'b001:  extend_load = {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'b010:  extend_load = {{(XLEN-32){raw[31]}}, raw[31:0]};
      3'b100:  extend_load = {{(XLEN-8){1'b0}}, raw[7:0]};
      3'b101:  extend_load = {{(XLEN-16){1'b0}}, raw[15:0]};
      3'b110:  extend_load = {{(XLEN-32){1'b0}}, raw[31:0]};
      default: extend_load = raw;
    endcase
  endfunction

  assign off_in_s    = alu_result[2:0];
  assign is_load_s   = (opcode == OP_LOAD);
  assign is_store_s  = (opcode == OP_STORE);
  assign is_mem_s    = is_load_s | is_store_s;
  assign addr_full_s = ADDR_W'(alu_result);

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

  assign trap_s = is_mem_s & misaligned(off_in_s, funct3[1:0]);
`else
  assign trap_s       = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_enable) begin
          if (is_mem_s && !trap_s) begin
            state_next_s = REQ;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (dc_req_ready) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = REQ;
        end
      end
      WAIT: begin
        if (dc_resp_valid) begin
          state_next_s = DONE;
        end else begin
          state_next_s = WAIT;
        end
      end
      DONE: begin
        if (wb_ack) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Registered request, result and latched-instruction outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_r       <= 3'd0;
      alu_result_out <= '0;
      opcode_out     <= 7'd0;
      dest_reg_out   <= 5'd0;
      dc_req_valid   <= 1'b0;
      dc_req_write   <= 1'b0;
      dc_req_addr    <= '0;
      dc_req_wdata   <= '0;
      dc_req_strb    <= 8'd0;
      loaded_data    <= '0;
      mem_done       <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_enable) begin
            funct3_r       <= funct3;
            alu_result_out <= alu_result;
            opcode_out     <= opcode;
            dest_reg_out   <= dest_reg;
            dc_req_addr    <= {addr_full_s[ADDR_W-1:3], 3'b000};
            dc_req_wdata   <= store_data << {off_in_s, 3'b000};
            dc_req_strb    <= (is_store_s && !trap_s) ? (size_mask(funct3[1:0]) << off_in_s) : 8'd0;
            dc_req_write   <= is_store_s;
            dc_req_valid   <= is_mem_s & ~trap_s;
            loaded_data    <= '0;
            mem_done       <= ~(is_mem_s & ~trap_s);
`ifdef MEM_MISALIGN_TRAP_EN
            mem_misalign   <= trap_s;
`endif
          end
        end
        REQ: begin
          if (dc_req_ready) begin
            dc_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (dc_resp_valid) begin
            if (opcode_out == OP_LOAD) begin
              loaded_data <= extend_load(dc_resp_rdata, alu_result_out[2:0], funct3_r);
            end
            mem_done <= 1'b1;
          end
        end
        DONE: begin
          if (wb_ack) begin
            mem_done <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mem_misalign <= 1'b0;
`endif
          end
        end
        default: begin
          dc_req_valid <= 1'b0;
          mem_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a byte-level reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_enable;
  logic [63:0] alu_result, store_data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  dest_reg;
  logic        dc_req_valid, dc_req_ready, dc_req_write;
  logic [63:0] dc_req_addr, dc_req_wdata;
  logic [7:0]  dc_req_strb;
  logic        dc_resp_valid;
  logic [63:0] dc_resp_rdata;
  logic [63:0] loaded_data, alu_result_out;
  logic [4:0]  dest_reg_out;
  logic [6:0]  opcode_out;
  logic        mem_done, wb_ack, mem_misalign;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  mem_access_stage #(.ADDR_W(64), .XLEN(64)) dut (
    .clk(clk), .reset(reset), .mem_enable(mem_enable),
    .alu_result(alu_result), .store_data(store_data), .opcode(opcode),
    .funct3(funct3), .dest_reg(dest_reg),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_write(dc_req_write),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_strb(dc_req_strb),
    .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .loaded_data(loaded_data), .alu_result_out(alu_result_out), .dest_reg_out(dest_reg_out),
    .opcode_out(opcode_out), .mem_done(mem_done), .wb_ack(wb_ack), .mem_misalign(mem_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  // Reference: pick the addressed bytes out of the doubleword, then extend.
  function automatic logic [63:0] load_model(input logic [63:0] rdata, input int off, input logic [2:0] f3);
    logic [63:0] r;
    int n;
    r = 64'd0;
    n = size_bytes(f3);
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && r[8*n-1])
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 64'(dc_req_valid), 64'd0);
    chk({tag, "_write"}, 64'(dc_req_write), 64'd0);
    chk({tag, "_addr"},  dc_req_addr,  64'd0);
    chk({tag, "_wdata"}, dc_req_wdata, 64'd0);
    chk({tag, "_strb"},  64'(dc_req_strb), 64'd0);
    chk({tag, "_ld"},    loaded_data,  64'd0);
    chk({tag, "_alu"},   alu_result_out, 64'd0);
    chk({tag, "_rd"},    64'(dest_reg_out), 64'd0);
    chk({tag, "_op"},    64'(opcode_out), 64'd0);
    chk({tag, "_done"},  64'(mem_done), 64'd0);
    chk({tag, "_mis"},   64'(mem_misalign), 64'd0);
  endtask

  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [63:0] rdata,
                         input int rdy_dly, input int rsp_dly, input int ack_dly);
    logic        is_ld, is_st, is_mem, trap;
    logic [4:0]  rd;
    logic [63:0] e_ld, e_wd, e_addr;
    logic [7:0]  e_strb;
    int off, n;
    rd     = 5'($urandom);
    is_ld  = (op == 7'b0000011);
    is_st  = (op == 7'b0100011);
    is_mem = is_ld | is_st;
    off    = int'(addr[2:0]);
    n      = size_bytes(f3);
    trap   = TRAP_EN && is_mem && (off % n != 0);
    e_addr = addr & ~64'h7;
    e_wd   = 64'd0;
    for (int i = 0; i < 8; i++)
      if (i >= off) e_wd[8*i +: 8] = sdata[8*(i-off) +: 8];
    e_strb = 8'd0;
    if (is_st && !trap)
      for (int i = 0; i < n; i++)
        if (off + i < 8) e_strb[off+i] = 1'b1;
    e_ld = (is_ld && !trap) ? load_model(rdata, off, f3) : 64'd0;

    @(negedge clk);
    alu_result = addr; store_data = sdata; opcode = op; funct3 = f3; dest_reg = rd;
    mem_enable = 1'b1;
    @(posedge clk); #1;
    mem_enable = 1'b0;
    if (is_mem && !trap) begin
      for (int k = 0; k <= rdy_dly; k++) begin
        chk("req_valid", 64'(dc_req_valid), 64'd1);
        chk("req_addr", dc_req_addr, e_addr);
        chk("req_strb", 64'(dc_req_strb), 64'(e_strb));
        chk("req_write", 64'(dc_req_write), 64'(is_st));
        if (is_st) chk("req_wdata", dc_req_wdata, e_wd);
        chk("done_early", 64'(mem_done), 64'd0);
        if (k == rdy_dly) dc_req_ready = 1'b1;
        @(posedge clk); #1;
      end
      dc_req_ready = 1'b0;
      chk("req_drop", 64'(dc_req_valid), 64'd0);
      for (int k = 0; k < rsp_dly; k++) begin
        chk("wait_done", 64'(mem_done), 64'd0);
        @(posedge clk); #1;
      end
      dc_resp_valid = 1'b1;
      dc_resp_rdata = rdata;
      @(posedge clk); #1;
      dc_resp_valid = 1'b0;
      dc_resp_rdata = {$urandom, $urandom};
    end else begin
      chk("no_req", 64'(dc_req_valid), 64'd0);
    end
    for (int k = 0; k <= ack_dly; k++) begin
      chk("mem_done", 64'(mem_done), 64'd1);
      chk("loaded_data", loaded_data, e_ld);
      chk("alu_out", alu_result_out, addr);
      chk("rd_out", 64'(dest_reg_out), 64'(rd));
      chk("op_out", 64'(opcode_out), 64'(op));
      chk("misalign", 64'(mem_misalign), 64'(trap));
      chk("done_req", 64'(dc_req_valid), 64'd0);
      if (k == ack_dly) wb_ack = 1'b1;
      @(posedge clk); #1;
    end
    wb_ack = 1'b0;
    chk("done_fall", 64'(mem_done), 64'd0);
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] a;
    reset = 1'b1; mem_enable = 1'b0; alu_result = 64'd0; store_data = 64'd0;
    opcode = 7'd0; funct3 = 3'd0; dest_reg = 5'd0; dc_req_ready = 1'b0;
    dc_resp_valid = 1'b0; dc_resp_rdata = 64'd0; wb_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    run_txn(7'b0000011, 3'b010, 64'h1004, 64'd0, 64'h8000_0000_0000_0000, 0, 0, 0);
    run_txn(7'b0000011, 3'b100, 64'h2007, 64'd0, 64'hAB00_0000_0000_0000, 0, 0, 0);
    run_txn(7'b0000011, 3'b000, 64'h2007, 64'd0, 64'hAB00_0000_0000_0000, 1, 2, 1);
    run_txn(7'b0100011, 3'b001, 64'h3002, 64'h1234, 64'hDEAD_BEEF_0000_0000, 4, 0, 0);
    run_txn(7'b0110011, 3'b000, 64'h55, 64'h0, 64'h0, 0, 0, 3);
    run_txn(7'b0000011, 3'b011, 64'h1003, 64'd0, 64'h0102_0304_0506_0708, 0, 1, 0);
    run_txn(7'b0100011, 3'b011, 64'h1003, 64'hCAFE_F00D_1122_3344, 64'd0, 0, 0, 0);
    run_txn(7'b0000011, 3'b111, 64'h4000, 64'd0, 64'hF0E1_D2C3_B4A5_9687, 0, 0, 0);

    // Abort an access in WAIT, then present a stale response in IDLE.
    @(negedge clk);
    alu_result = 64'h5008; opcode = 7'b0000011; funct3 = 3'b011; dest_reg = 5'd7;
    mem_enable = 1'b1; dc_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_enable = 1'b0;
    @(posedge clk); #1;
    dc_req_ready = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_zero_outputs("abort");
    dc_resp_valid = 1'b1; dc_resp_rdata = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    dc_resp_valid = 1'b0;
    chk("late_done", 64'(mem_done), 64'd0);
    chk("late_ld", loaded_data, 64'd0);
    chk("late_req", 64'(dc_req_valid), 64'd0);
    run_txn(7'b0000011, 3'b011, 64'h5008, 64'd0, 64'h9999_8888_7777_6666, 0, 0, 0);

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 7'b0000011;
        4, 5, 6, 7: op = 7'b0100011;
        default: begin
          op = 7'($urandom);
          if (op == 7'b0000011 || op == 7'b0100011) op = 7'b0110011;
        end
      endcase
      f3 = 3'($urandom);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a = a & ~64'(size_bytes(f3) - 1);
      run_txn(op, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
